// File: rtl/memory_port_sequencer_pkg.sv
// Shared types for the memory port sequencer: FSM encoding and queue entry layout.
// The entry is 109 bits wide: {store_ack, rw, mmu_mode, mmu_ps, pdt, order, mask, addr, data}.
package mist1032isa_memory_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  localparam int W_MMU_MODE = 2;
  localparam int W_MMU_PS   = 3;
  localparam int W_PDT      = 32;
  localparam int W_ORDER    = 2;
  localparam int W_MASK     = 4;
  localparam int W_ADDR     = 32;
  localparam int W_DATA     = 32;
  localparam int W_RDATA    = 64;
  localparam int W_FLAGS    = 24;

  localparam int ENTRY_W = 2 + W_MMU_MODE + W_MMU_PS + W_PDT + W_ORDER
                         + W_MASK + W_ADDR + W_DATA;

  typedef struct packed {
    logic                  store_ack;
    logic                  rw;
    logic [W_MMU_MODE-1:0] mmu_mode;
    logic [W_MMU_PS-1:0]   mmu_ps;
    logic [W_PDT-1:0]      pdt;
    logic [W_ORDER-1:0]    order;
    logic [W_MASK-1:0]     mask;
    logic [W_ADDR-1:0]     addr;
    logic [W_DATA-1:0]     data;
  } mem_req_t;

endpackage

// File: rtl/memory_port_sequencer_if.sv
// Arbiter-side and bus-side signals of the memory port sequencer.
// slave = the sequencer itself, master = its environment (arbiter + memory bus).
interface memory_port_sequencer_if;
  import mist1032isa_memory_port_pkg::*;

  // arbiter request side
  logic                  iREQ;
  logic                  oLOCK;
  logic                  iSTORE_ACK;
  logic [W_MMU_MODE-1:0] iMMU_MODE;
  logic [W_MMU_PS-1:0]   iMMU_PS;
  logic [W_PDT-1:0]      iPDT;
  logic [W_ORDER-1:0]    iORDER;
  logic [W_MASK-1:0]     iMASK;
  logic                  iRW;
  logic [W_ADDR-1:0]     iADDR;
  logic [W_DATA-1:0]     iDATA;
  // arbiter response side
  logic                  oVALID;
  logic                  iBUSY;
  logic                  oSTORE_ACK;
  logic [W_RDATA-1:0]    oDATA;
  logic [W_FLAGS-1:0]    oMMU_FLAGS;
  // memory bus command
  logic                  oBUS_REQ;
  logic                  iBUS_ACK;
  logic [W_MMU_MODE-1:0] oBUS_MMU_MODE;
  logic [W_MMU_PS-1:0]   oBUS_MMU_PS;
  logic [W_PDT-1:0]      oBUS_PDT;
  logic [W_ORDER-1:0]    oBUS_ORDER;
  logic [W_MASK-1:0]     oBUS_MASK;
  logic                  oBUS_RW;
  logic [W_ADDR-1:0]     oBUS_ADDR;
  logic [W_DATA-1:0]     oBUS_DATA;
  // memory bus response
  logic                  iBUS_VALID;
  logic [W_RDATA-1:0]    iBUS_DATA;
  logic [W_FLAGS-1:0]    iBUS_MMU_FLAGS;
  logic                  oERROR;

  modport slave (
    input  iREQ, iSTORE_ACK, iMMU_MODE, iMMU_PS, iPDT, iORDER, iMASK, iRW, iADDR, iDATA,
    output oLOCK,
    output oVALID, oSTORE_ACK, oDATA, oMMU_FLAGS,
    input  iBUSY,
    output oBUS_REQ, oBUS_MMU_MODE, oBUS_MMU_PS, oBUS_PDT, oBUS_ORDER, oBUS_MASK,
           oBUS_RW, oBUS_ADDR, oBUS_DATA,
    input  iBUS_ACK, iBUS_VALID, iBUS_DATA, iBUS_MMU_FLAGS,
    output oERROR
  );

  modport master (
    output iREQ, iSTORE_ACK, iMMU_MODE, iMMU_PS, iPDT, iORDER, iMASK, iRW, iADDR, iDATA,
    input  oLOCK,
    input  oVALID, oSTORE_ACK, oDATA, oMMU_FLAGS,
    output iBUSY,
    input  oBUS_REQ, oBUS_MMU_MODE, oBUS_MMU_PS, oBUS_PDT, oBUS_ORDER, oBUS_MASK,
           oBUS_RW, oBUS_ADDR, oBUS_DATA,
    output iBUS_ACK, iBUS_VALID, iBUS_DATA, iBUS_MMU_FLAGS,
    input  oERROR
  );

endinterface

// File: rtl/memory_port_sequencer_fifo.sv
// Generic synchronous FIFO with first-word-fall-through read port.
// Push when full and pop when empty are ignored; the caller owns the error policy.
module memory_port_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int DEPTH_N = 2
) (
  input  logic               iCLOCK,
  input  logic               iRESET,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_data,
  output logic [DEPTH_N:0]   o_count,
  output logic               o_full,
  output logic               o_empty
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [DEPTH_N-1:0] r_wr_ptr;
  logic [DEPTH_N-1:0] r_rd_ptr;
  logic [DEPTH_N:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == (DEPTH_N+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so pointer wrap is the natural overflow
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // storage needs no reset: emptiness is tracked by the pointers and count
  always_ff @(posedge iCLOCK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/memory_port_sequencer.sv
// Queues arbiter memory requests and issues them one at a time on the external bus,
// holding each bus response in a return register until the core side accepts it.
module memory_port_sequencer
  import mist1032isa_memory_port_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DEPTH_N = 2
) (
  input  logic                    iCLOCK,
  input  logic                    iRESET,
  memory_port_sequencer_if.slave  io
);

  seq_state_e         r_state;
  logic               r_store_ack;
  mem_req_t           w_in;
  mem_req_t           w_head;
  logic [ENTRY_W-1:0] w_head_bits;
  logic [DEPTH_N:0]   w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  assign w_in = '{
    store_ack: io.iSTORE_ACK,
    rw:        io.iRW,
    mmu_mode:  io.iMMU_MODE,
    mmu_ps:    io.iMMU_PS,
    pdt:       io.iPDT,
    order:     io.iORDER,
    mask:      io.iMASK,
    addr:      io.iADDR,
    data:      io.iDATA
  };
  assign w_head = mem_req_t'(w_head_bits);

  assign w_push = io.iREQ && !w_full;
  // the head leaves the queue when the command slot is free: idle, or a response just consumed
  assign w_pop  = !w_empty &&
                  ((r_state == ST_IDLE) || ((r_state == ST_RESP) && !io.iBUSY));

  // one skid slot because the arbiter reacts to the lock a cycle late
  assign io.oLOCK = (w_count >= (DEPTH_N+1)'(DEPTH - 1));

  memory_port_fifo #(
    .WIDTH   (ENTRY_W),
    .DEPTH   (DEPTH),
    .DEPTH_N (DEPTH_N)
  ) u_fifo (
    .iCLOCK  (iCLOCK),
    .iRESET  (iRESET),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // bus command registers, loaded on every pop and held stable while issued
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_store_ack      <= 1'b0;
      io.oBUS_MMU_MODE <= '0;
      io.oBUS_MMU_PS   <= '0;
      io.oBUS_PDT      <= '0;
      io.oBUS_ORDER    <= '0;
      io.oBUS_MASK     <= '0;
      io.oBUS_RW       <= 1'b0;
      io.oBUS_ADDR     <= '0;
      io.oBUS_DATA     <= '0;
    end else if (w_pop) begin
      r_store_ack      <= w_head.store_ack;
      io.oBUS_MMU_MODE <= w_head.mmu_mode;
      io.oBUS_MMU_PS   <= w_head.mmu_ps;
      io.oBUS_PDT      <= w_head.pdt;
      io.oBUS_ORDER    <= w_head.order;
      io.oBUS_MASK     <= w_head.mask;
      io.oBUS_RW       <= w_head.rw;
      io.oBUS_ADDR     <= w_head.addr;
      io.oBUS_DATA     <= w_head.data;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state       <= ST_IDLE;
      io.oBUS_REQ   <= 1'b0;
      io.oVALID     <= 1'b0;
      io.oSTORE_ACK <= 1'b0;
      io.oDATA      <= '0;
      io.oMMU_FLAGS <= '0;
      io.oERROR     <= 1'b0;
    end else begin
      if ((io.iREQ && w_full) || (io.iBUS_VALID && (r_state != ST_WAIT)))
        io.oERROR <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            io.oBUS_REQ <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (io.iBUS_ACK) begin
            io.oBUS_REQ <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (io.iBUS_VALID) begin
            io.oVALID     <= 1'b1;
            io.oSTORE_ACK <= r_store_ack;
            io.oDATA      <= r_store_ack ? '0 : io.iBUS_DATA;
            io.oMMU_FLAGS <= io.iBUS_MMU_FLAGS;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!io.iBUSY) begin
            io.oVALID <= 1'b0;
            if (w_pop) begin
              io.oBUS_REQ <= 1'b1;
              r_state     <= ST_ISSUE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
